// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: NRD read ports, an ALU/link write port, a load writeback port and a per-register load scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and busy clears to the read ports.
module arm_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int NRD    = 3,
  parameter int PC_IDX = 15,
  parameter int LR_IDX = 14,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [1:0]            wr_mode,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W-1:0]     pc_plus8,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  ld_issue,
  input  logic [AW-1:0]         ld_issue_addr,
  output logic                  busy_any
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [DATA_W-1:0] lr_val;

  assign lr_val = pc_plus8 - DATA_W'(4);

  // Write priority: load port, then ALU write, then link write, then the free-running PC update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ld_we && ld_addr == AW'(i))
          regs[i] <= ld_data;
        else if (wr_mode == 2'b01 && wr_addr == AW'(i))
          regs[i] <= wr_data;
        else if (wr_mode == 2'b11 && i == LR_IDX)
          regs[i] <= lr_val;
        else if (i == PC_IDX)
          regs[i] <= pc_plus8;

        // A new issue outranks a writeback of the previous load to the same register.
        if (ld_issue && ld_issue_addr == AW'(i) && i != PC_IDX)
          busy[i] <= 1'b1;
        else if (ld_we && ld_addr == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
      if (ld_we && ld_addr == addr)
        data = ld_data;
      else if (wr_mode == 2'b01 && wr_addr == addr)
        data = wr_data;
      else if (wr_mode == 2'b11 && addr == AW'(LR_IDX))
        data = lr_val;
      else if (addr == AW'(PC_IDX))
        data = pc_plus8;
      if (ld_we && ld_addr == addr && !(ld_issue && ld_issue_addr == addr))
        bsy = 1'b0;
`endif
    end

    // Force quiet outputs while reset is held, including any forwarded values.
    assign rd_data[k*DATA_W +: DATA_W] = reset_n ? data : '0;
    assign rd_busy[k]                  = reset_n & bsy;
  end

  assign busy_any = reset_n & (|busy);

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Self-checking bench for arm_regfile_mp: vector table with a scoreboard queue plus hand sequences.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN.
module tb_arm_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;

  logic            clk;
  logic            reset_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic [1:0]      wr_mode;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   pc_plus8;
  logic            ld_we;
  logic [AW-1:0]   ld_addr;
  logic [DW-1:0]   ld_data;
  logic            ld_issue;
  logic [AW-1:0]   ld_issue_addr;
  logic            busy_any;

  int checks = 0;
  int passed = 0;

  arm_regfile_mp dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_plus8(pc_plus8),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .busy_any(busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  wm;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc8;
    logic        lw;
    logic [3:0]  la;
    logic [31:0] ld;
    logic        li;
    logic [3:0]  lia;
    logic [11:0] ra;
    logic [95:0] ed;
    logic [2:0]  eb;
    logic        ea;
  } vec_t;

  typedef struct {
    string       name;
    logic [95:0] d;
    logic [2:0]  b;
    logic        a;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(string n, logic [1:0] wm, logic [3:0] wa, logic [31:0] wd,
                              logic [31:0] pc8, logic lw, logic [3:0] la, logic [31:0] ld,
                              logic li, logic [3:0] lia, logic [3:0] r0, logic [3:0] r1,
                              logic [3:0] r2, logic [31:0] e0, logic [31:0] e1,
                              logic [31:0] e2, logic [2:0] eb, logic ea);
    vec_t v;
    v.name = n; v.wm = wm; v.wa = wa; v.wd = wd; v.pc8 = pc8;
    v.lw = lw; v.la = la; v.ld = ld; v.li = li; v.lia = lia;
    v.ra = {r2, r1, r0};
    v.ed = {e2, e1, e0};
    v.eb = eb; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_writes();
    wr_mode  = 2'b00;
    ld_we    = 1'b0;
    ld_issue = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    wr_mode = v.wm; wr_addr = v.wa; wr_data = v.wd; pc_plus8 = v.pc8;
    ld_we = v.lw; ld_addr = v.la; ld_data = v.ld;
    ld_issue = v.li; ld_issue_addr = v.lia;
    rd_addr = v.ra;
    e.name = v.name; e.d = v.ed; e.b = v.eb; e.a = v.ea;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < NR; k++) begin
      check($sformatf("%s.data%0d", e.name, k), rd_data[k*DW +: DW], e.d[k*32 +: 32]);
      check($sformatf("%s.busy%0d", e.name, k), 32'(rd_busy[k]), 32'(e.b[k]));
    end
    check($sformatf("%s.busy_any", e.name), 32'(busy_any), 32'(e.a));
  endtask

  initial begin
    logic [31:0] exp_v;

    reset_n = 1'b1;
    pc_plus8 = 32'h108;
    wr_addr = '0; wr_data = '0; ld_addr = '0; ld_data = '0; ld_issue_addr = '0;
    idle_writes();
    rd_addr = {4'd15, 4'd1, 4'd0};
    #1 reset_n = 1'b0;

    // Reset held with the clock running: everything reads as zero.
    repeat (2) @(posedge clk);
    #2;
    check("rst.data0", rd_data[0 +: DW], 32'h0);
    check("rst.data1", rd_data[DW +: DW], 32'h0);
    check("rst.data2", rd_data[2*DW +: DW], 32'h0);
    check("rst.busy", 32'(rd_busy), 32'h0);
    check("rst.busy_any", 32'(busy_any), 32'h0);
    #3 reset_n = 1'b1;
    @(posedge clk); #2;
    check("rel.data0", rd_data[0 +: DW], 32'h0);
    check("rel.data1", rd_data[DW +: DW], 32'h0);
    check("rel.pc", rd_data[2*DW +: DW], 32'h108);

    // Same-cycle read of a register being written.
    wr_mode = 2'b01; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
    rd_addr = {4'd15, 4'd1, 4'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hDEADBEEF;
`else
    exp_v = 32'h0;
`endif
    check("samecyc.r3", rd_data[0 +: DW], exp_v);
    @(posedge clk); #1 idle_writes(); #1;
    check("nextcyc.r3", rd_data[0 +: DW], 32'hDEADBEEF);

    // Busy set by an issue, then same-cycle view of its writeback.
    ld_issue = 1'b1; ld_issue_addr = 4'd9;
    rd_addr = {4'd15, 4'd1, 4'd9};
    @(posedge clk); #1 idle_writes(); #1;
    check("r9.busy_set", 32'(rd_busy[0]), 32'h1);
    ld_we = 1'b1; ld_addr = 4'd9; ld_data = 32'h9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r9.wb_samecyc_busy", 32'(rd_busy[0]), 32'h0);
    check("r9.wb_samecyc_data", rd_data[0 +: DW], 32'h9);
`else
    check("r9.wb_samecyc_busy", 32'(rd_busy[0]), 32'h1);
    check("r9.wb_samecyc_data", rd_data[0 +: DW], 32'h0);
`endif
    @(posedge clk); #1 idle_writes(); #1;
    check("r9.busy_clr", 32'(rd_busy[0]), 32'h0);
    check("r9.data", rd_data[0 +: DW], 32'h9);

    //            name           wm     wa  wd            pc8         lw  la  ld           li  lia r0  r1  r2  e0            e1            e2            eb      ea
    vecs.push_back(mk("wr_r4",      2'b01, 4, 32'h12345678, 32'h108,  0, 0, 32'h0,  0, 0, 4, 3, 15, 32'h12345678, 32'hDEADBEEF, 32'h108,      3'b000, 0));
    vecs.push_back(mk("link",       2'b11, 0, 32'h0,        32'h2008, 0, 0, 32'h0,  0, 0, 14, 15, 4, 32'h2004,     32'h2008,     32'h12345678, 3'b000, 0));
    vecs.push_back(mk("ld_wins",    2'b01, 5, 32'h22,       32'h2008, 1, 5, 32'h11, 0, 0, 5, 14, 15, 32'h11,       32'h2004,     32'h2008,     3'b000, 0));
    vecs.push_back(mk("issue_r7",   2'b00, 0, 32'h0,        32'h2008, 0, 0, 32'h0,  1, 7, 7, 5, 0,   32'h0,        32'h11,       32'h0,        3'b001, 1));
    vecs.push_back(mk("wb_r7",      2'b00, 0, 32'h0,        32'h2008, 1, 7, 32'h55, 0, 0, 7, 5, 0,   32'h55,       32'h11,       32'h0,        3'b000, 0));
    vecs.push_back(mk("iss_wb_r7",  2'b00, 0, 32'h0,        32'h2008, 1, 7, 32'h66, 1, 7, 7, 5, 0,   32'h66,       32'h11,       32'h0,        3'b001, 1));
    vecs.push_back(mk("wb_r7_b",    2'b00, 0, 32'h0,        32'h2008, 1, 7, 32'h77, 0, 0, 7, 5, 0,   32'h77,       32'h11,       32'h0,        3'b000, 0));
    vecs.push_back(mk("issue_pc",   2'b00, 0, 32'h0,        32'h2008, 0, 0, 32'h0,  1, 15, 15, 7, 0, 32'h2008,     32'h77,       32'h0,        3'b000, 0));
    vecs.push_back(mk("reserved",   2'b10, 3, 32'h1234,     32'h2008, 0, 0, 32'h0,  0, 0, 3, 4, 15,  32'hDEADBEEF, 32'h12345678, 32'h2008,     3'b000, 0));
    vecs.push_back(mk("two_ports",  2'b01, 0, 32'hA5A5,     32'h2008, 1, 1, 32'h5A, 0, 0, 0, 1, 3,   32'hA5A5,     32'h5A,       32'hDEADBEEF, 3'b000, 0));
    vecs.push_back(mk("wr_iss_r2",  2'b01, 2, 32'h99,       32'h2008, 0, 0, 32'h0,  1, 2, 2, 0, 1,   32'h99,       32'hA5A5,     32'h5A,       3'b001, 1));
    vecs.push_back(mk("wr_busy_r2", 2'b01, 2, 32'hAB,       32'h2008, 0, 0, 32'h0,  0, 0, 2, 0, 1,   32'hAB,       32'hA5A5,     32'h5A,       3'b001, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(posedge clk); #1 idle_writes(); #1;
      check_output();
    end

    // Branch through the ALU port overrides the PC update.
    wr_mode = 2'b01; wr_addr = 4'd15; wr_data = 32'h4000;
    rd_addr = {4'd15, 4'd15, 4'd2};
    @(posedge clk); #1 idle_writes(); #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'h2008;
`else
    exp_v = 32'h4000;
`endif
    check("branch.pc", rd_data[DW +: DW], exp_v);
    check("branch.r2_busy", 32'(rd_busy[0]), 32'h1);

    // Asynchronous reset in the middle of a cycle with a load pending.
    #1 reset_n = 1'b0;
    #1;
    check("async.busy_any", 32'(busy_any), 32'h0);
    check("async.r2_busy", 32'(rd_busy[0]), 32'h0);
    check("async.r2", rd_data[0 +: DW], 32'h0);
    check("async.pc", rd_data[DW +: DW], 32'h0);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;
    check("postrst.r2", rd_data[0 +: DW], 32'h0);
    check("postrst.r2_busy", 32'(rd_busy[0]), 32'h0);
    check("postrst.pc", rd_data[DW +: DW], 32'h2008);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
